// File: rtl/esc_pkg.sv
// rtl/esc_pkg.sv - shared defaults and the frame-fit check for the ESC array.
package esc_pkg;

  localparam int DEF_N_CH      = 4;
  localparam int DEF_SPD_W     = 11;
  localparam int DEF_PERIOD_W  = 18;
  localparam int DEF_MIN_PULSE = 50000;
  localparam int DEF_SCALE     = 3;
  localparam int DEF_SLEW      = 0;

  // The widest possible pulse must end strictly before the frame wraps.
  function automatic bit pulse_fits(input int period_w, input int spd_w,
                                    input int min_pulse, input int scale);
    longint max_pulse;
    max_pulse = longint'(min_pulse) + ((longint'(1) << spd_w) - 1) * longint'(scale);
    return max_pulse < (longint'(1) << period_w);
  endfunction

endpackage

// File: rtl/esc_if.sv
// rtl/esc_if.sv - speed/command inputs and PWM/telemetry outputs of the ESC array.
interface esc_if
  import esc_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int SPD_W = DEF_SPD_W
);

  logic [N_CH*SPD_W-1:0] spd;
  logic                  motors_off;
  logic [N_CH-1:0]       pwm;
  logic                  frame_strt;
  logic [N_CH*SPD_W-1:0] spd_applied;

  modport master (
    output spd, motors_off,
    input  pwm, frame_strt, spd_applied
  );

  modport slave (
    input  spd, motors_off,
    output pwm, frame_strt, spd_applied
  );

endinterface

// File: rtl/esc_channel.sv
// rtl/esc_channel.sv - one motor: slew limiter, applied speed, pulse width and PWM compare.
module esc_channel
  import esc_pkg::*;
#(
  parameter int SPD_W     = DEF_SPD_W,
  parameter int PERIOD_W  = DEF_PERIOD_W,
  parameter int MIN_PULSE = DEF_MIN_PULSE,
  parameter int SCALE     = DEF_SCALE,
  parameter int SLEW      = DEF_SLEW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                boundary_i,
  input  logic [PERIOD_W-1:0] cnt_i,
  input  logic [SPD_W-1:0]    tgt_i,
  input  logic                motors_off_i,
  input  logic                off_frame_i,
  output logic                pwm_o,
  output logic [SPD_W-1:0]    applied_o
);

  localparam logic [SPD_W:0]    SLEW_V  = (SPD_W+1)'(SLEW);
  localparam logic [PERIOD_W-1:0] MIN_V   = PERIOD_W'(MIN_PULSE);
  localparam logic [PERIOD_W-1:0] SCALE_V = PERIOD_W'(SCALE);

  logic [SPD_W-1:0]    applied_q, applied_d, slewed;
  logic [PERIOD_W-1:0] pulse_q, pulse_d;
  logic                pwm_q, pwm_d;
  logic [SPD_W:0]      up_gap, dn_gap;

  // Gaps are only used on the side where tgt lies, so the step never crosses tgt or wraps.
  always_comb begin
    up_gap = {1'b0, tgt_i} - {1'b0, applied_q};
    dn_gap = {1'b0, applied_q} - {1'b0, tgt_i};
    slewed = tgt_i;
    if (SLEW != 0) begin
      if ((tgt_i > applied_q) && (up_gap > SLEW_V)) begin
        slewed = applied_q + SLEW_V[SPD_W-1:0];
      end else if ((tgt_i < applied_q) && (dn_gap > SLEW_V)) begin
        slewed = applied_q - SLEW_V[SPD_W-1:0];
      end
    end
  end

  always_comb begin
    applied_d = applied_q;
    pulse_d   = pulse_q;
    if (boundary_i) begin
      applied_d = motors_off_i ? '0 : slewed;
      pulse_d   = MIN_V + PERIOD_W'(applied_d) * SCALE_V;
    end
  end

  // pulse_d already holds the new width on the boundary cycle, so the first high cycle uses it.
  assign pwm_d = (cnt_i < pulse_d) && !motors_off_i && !off_frame_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      applied_q <= '0;
      pulse_q   <= MIN_V;
      pwm_q     <= 1'b0;
    end else begin
      applied_q <= applied_d;
      pulse_q   <= pulse_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_o     = pwm_q;
  assign applied_o = applied_q;

endmodule

// File: rtl/esc_array.sv
// rtl/esc_array.sv - N-channel ESC driver sharing one frame counter, with frame strobe and readback.
module esc_array
  import esc_pkg::*;
#(
  parameter int N_CH      = DEF_N_CH,
  parameter int SPD_W     = DEF_SPD_W,
  parameter int PERIOD_W  = DEF_PERIOD_W,
  parameter int MIN_PULSE = DEF_MIN_PULSE,
  parameter int SCALE     = DEF_SCALE,
  parameter int SLEW      = DEF_SLEW
) (
  input logic  clk,
  input logic  rst_n,
  esc_if.slave bus
);

  if (!pulse_fits(PERIOD_W, SPD_W, MIN_PULSE, SCALE)) begin : g_pulse_chk
    $fatal(1, "esc_array: MIN_PULSE + max speed * SCALE does not fit in the frame");
  end

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                off_frame_q, off_frame_d;
  logic                frame_strt_q, frame_strt_d;
  logic                boundary;

  assign boundary = (cnt_q == '0);

  // off_frame_d is the effective flag for this cycle: on a boundary it already reflects motors_off.
  always_comb begin
    cnt_d        = cnt_q + 1'b1;
    frame_strt_d = boundary;
    off_frame_d  = boundary ? bus.motors_off : off_frame_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      off_frame_q  <= 1'b0;
      frame_strt_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      off_frame_q  <= off_frame_d;
      frame_strt_q <= frame_strt_d;
    end
  end

  assign bus.frame_strt = frame_strt_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    esc_channel #(
      .SPD_W    (SPD_W),
      .PERIOD_W (PERIOD_W),
      .MIN_PULSE(MIN_PULSE),
      .SCALE    (SCALE),
      .SLEW     (SLEW)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .boundary_i  (boundary),
      .cnt_i       (cnt_q),
      .tgt_i       (bus.spd[g*SPD_W +: SPD_W]),
      .motors_off_i(bus.motors_off),
      .off_frame_i (off_frame_d),
      .pwm_o       (bus.pwm[g]),
      .applied_o   (bus.spd_applied[g*SPD_W +: SPD_W])
    );
  end

endmodule

// File: doc/esc_array.md
Name: esc_array

Overview:
- Parametrised successor to the fixed four-motor ESC block. Drives N_CH electronic speed controllers from one shared frame counter.
- Adds three behaviours the fixed block lacks:
  - per-frame glitch-free speed latching;
  - optional slew-rate limiting of each channel's speed;
  - a frame-start strobe and applied-speed readback for telemetry.
- Sits between flght_cntrl (speed inputs) and the motor PWM pins. motors_off comes from cmd_cfg.

Parameters:
- N_CH, 4, number of motor channels.
- SPD_W, 11, width of each channel speed.
- PERIOD_W, 18, frame counter width; frame length = 2^PERIOD_W clocks (5.24 ms at 50 MHz).
- MIN_PULSE, 50000, pulse width in clocks at speed 0 (1 ms).
- SCALE, 3, clocks of pulse added per speed LSB.
- SLEW, 0, maximum speed change per frame in LSBs; 0 disables limiting.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- spd  in  N_CH*SPD_W  packed target speeds; channel i at [i*SPD_W +: SPD_W].
- motors_off  in  1  forces all PWM outputs low and zeroes applied speeds.
- pwm  out  N_CH  ESC pulse per channel.
- frame_strt  out  1  one-cycle strobe at each frame boundary.
- spd_applied  out  N_CH*SPD_W  speeds currently in use (post-slew), same packing as spd.

Behaviour:
- Reset values: cnt=0, all applied speeds=0, pulse registers=MIN_PULSE, pwm=0, frame_strt=0.
- Frame counter cnt:
  - free-running, increments every clock;
  - wraps from 2^PERIOD_W-1 to 0 with no gap.
- Frame boundary is the cycle where cnt==0.
  - frame_strt is registered; it is high on the cycle after cnt==0, exactly one cycle per frame.
  - On this cycle, for each channel i:
    - tgt = spd[i] sampled this cycle.
    - If motors_off: applied_i <= 0.
    - Else if SLEW==0: applied_i <= tgt.
    - Else if |tgt - applied_i| <= SLEW: applied_i <= tgt.
    - Else: applied_i moves toward tgt by exactly SLEW. Compute unsigned, with no wrap; applied never goes below 0 or above 2^SPD_W-1.
    - pulse_i <= MIN_PULSE + next_applied_i*SCALE, width PERIOD_W.
- spd changes between boundaries have no effect until the next boundary. A pulse in flight is never truncated or extended by a spd change.
- PWM generation:
  - pwm[i] is a registered copy of (cnt < pulse_i) && !motors_off && !off_frame.
  - Rising edge falls on the cycle after cnt==0; high time is exactly pulse_i clocks.
- motors_off:
  - Sampled every cycle; pwm goes low on the next clock, including mid-pulse.
  - off_frame is set at a boundary where motors_off=1. It holds pwm low for that whole frame even if motors_off deasserts mid-frame.
  - After release, applied speeds restart from 0. With SLEW>0 they therefore ramp up.
- After reset with motors_off=0, every channel emits MIN_PULSE (idle/arm pulse) from the first frame.
- Elaboration check: MIN_PULSE + (2^SPD_W-1)*SCALE < 2^PERIOD_W; violation is a fatal error.
- Reset mid-frame: all state returns to reset values immediately. pwm drops asynchronously.

Decomposition:
- Package esc_pkg holds:
  - default parameter constants (DEF_PERIOD_W, DEF_MIN_PULSE, DEF_SCALE);
  - the max-pulse check function.
- Sub-module esc_channel, instantiated N_CH times:
  - inputs: frame boundary, shared cnt, target speed, motors_off, off_frame;
  - contains the slew limiter, applied register, pulse register and PWM compare.
- Top level owns cnt, off_frame, frame_strt and the spd/spd_applied packing.

Test Plan:
- Reset, defaults, spd all 0: each pwm high exactly 50000 clocks starting 1 cycle after cnt==0; frame_strt period 262144 clocks.
- spd ch0=1000, ch3=2047 applied before a boundary: ch0 high 53000 clocks, ch3 high 56141 clocks; spd_applied matches next cycle.
- spd ch1 changed 0->500 at cnt=20000 mid-pulse: current pulse stays 50000; next frame 51500.
- SLEW=100, spd 0->350: applied 100, 200, 300, 350 over four frames. Then 350->0 gives 250, 150, 50, 0.
- motors_off asserted at cnt=30000: all pwm low next clock. Deassert at cnt=100000: pwm stays low rest of frame. With SLEW=100 and spd=350, next frame applied=100 (pulse 50300).
- rst_n dropped mid-pulse: pwm low immediately. After release, cnt restarts at 0 and applied=0.
